// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed little-endian byte stream
// into 32-bit words and holds the core in reset until the image is loaded. Optional CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LEN0, ST_LEN1, ST_CHK, ST_DATA, ST_WRITE, ST_FIN, ST_ERR
`ifdef CHECKSUM_EN
        , ST_CSUM
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);

    state_t              state_r;
    logic [15:0]         count_r;
    logic [15:0]         word_idx_r;
    logic [1:0]          byte_idx_r;
    logic [23:0]         word_r;
    logic                rx_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                cpu_hold_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                accept_s;
    logic                last_word_s;
    logic                count_ok_s;
    logic [ADDR_W-1:0]   wr_addr_s;

`ifdef CHECKSUM_EN
    logic [7:0]          csum_r;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s    = rx_valid & rx_ready_r;
    assign last_word_s = (word_idx_r == (count_r - 16'd1));
    assign count_ok_s  = (count_r != 16'd0) && ({1'b0, count_r} <= MAX_WORDS);
    // Address arithmetic is ADDR_W wide so BASE_ADDR+word_idx wraps naturally.
    assign wr_addr_s   = BASE_W + word_idx_r[ADDR_W-1:0];

    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

    // Loader FSM; every output is registered and set on entry to the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 16'd0;
            word_idx_r  <= 16'd0;
            byte_idx_r  <= 2'd0;
            word_r      <= 24'd0;
            rx_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_W;
            mem_wdata_r <= 32'd0;
            cpu_hold_r  <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef CHECKSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_LEN0;
                        rx_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        err_r      <= 1'b0;
                        word_idx_r <= 16'd0;
                        byte_idx_r <= 2'd0;
`ifdef CHECKSUM_EN
                        csum_r     <= 8'd0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (accept_s) begin
                        count_r[7:0] <= rx_data;
                        state_r      <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (accept_s) begin
                        count_r[15:8] <= rx_data;
                        state_r       <= ST_CHK;
                        rx_ready_r    <= 1'b0;
                        cpu_hold_r    <= 1'b1;
                    end
                end
                ST_CHK: begin
                    if (count_ok_s) begin
                        state_r    <= ST_DATA;
                        rx_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
`ifdef CHECKSUM_EN
                        csum_r <= csum_update(csum_r, rx_data);
`endif
                        case (byte_idx_r)
                            2'd0: word_r[7:0]   <= rx_data;
                            2'd1: word_r[15:8]  <= rx_data;
                            2'd2: word_r[23:16] <= rx_data;
                            default: begin
                                mem_we_r    <= 1'b1;
                                mem_addr_r  <= wr_addr_s;
                                mem_wdata_r <= {rx_data, word_r};
                                rx_ready_r  <= 1'b0;
                                state_r     <= ST_WRITE;
                            end
                        endcase
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                end
                ST_WRITE: begin
                    if (last_word_s) begin
`ifdef CHECKSUM_EN
                        state_r    <= ST_CSUM;
                        rx_ready_r <= 1'b1;
`else
                        state_r    <= ST_FIN;
                        done_r     <= 1'b1;
                        cpu_hold_r <= 1'b0;
`endif
                    end else begin
                        word_idx_r <= word_idx_r + 16'd1;
                        state_r    <= ST_DATA;
                        rx_ready_r <= 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                ST_CSUM: begin
                    if (accept_s) begin
                        rx_ready_r <= 1'b0;
                        if (rx_data == csum_r) begin
                            state_r    <= ST_FIN;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            state_r <= ST_ERR;
                            err_r   <= 1'b1;
                        end
                    end
                end
`endif
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
